// File: rtl/pe_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : pe_seq_ctrl_if
// Brief   : Host, global-buffer and PE signal bundle for the PE sequencer.
// Revision: 1.0
// ============================================================================
interface pe_seq_ctrl_if #(
  parameter int GB_AW = 8,
  parameter int PE_AW = 6
);
  logic             start;
  logic             busy;
  logic             done;
  logic             err;
  logic [31:0]      result;
  logic             gb_en;
  logic [GB_AW-1:0] gb_addr;
  logic [31:0]      gb_dout;
  logic             pe_clr_n;
  logic [PE_AW-1:0] pe_addr;
  logic [31:0]      pe_din;
  logic             pe_we;
  logic [31:0]      pe_ain;
  logic             pe_valid;
  logic             pe_dvalid;
  logic [31:0]      pe_dout;

  modport master (
    input  start, gb_dout, pe_dvalid, pe_dout,
    output busy, done, err, result, gb_en, gb_addr,
           pe_clr_n, pe_addr, pe_din, pe_we, pe_ain, pe_valid
  );

  modport slave (
    output start, gb_dout, pe_dvalid, pe_dout,
    input  busy, done, err, result, gb_en, gb_addr,
           pe_clr_n, pe_addr, pe_din, pe_we, pe_ain, pe_valid
  );
endinterface
`default_nettype wire

// File: rtl/pe_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pe_seq_ctrl
// Brief   : Runs one dot-product job on a PE: clear, load N weights, stream N
//           inputs, return the final accumulator value.
// Revision: 1.0
// ============================================================================
module pe_seq_ctrl #(
  parameter int N       = 16,
  parameter int PE_AW   = 6,
  parameter int GB_AW   = 8,
  parameter int W_BASE  = 0,
  parameter int X_BASE  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic          aclk,
  input  logic          aresetn,
  pe_seq_ctrl_if.master bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0]    LAST_IDX = IW'(N - 1);
  localparam logic [CW-1:0]    TO_LAST  = CW'(TIMEOUT - 1);
  localparam logic [GB_AW-1:0] W_BASE_A = GB_AW'(W_BASE);
  localparam logic [GB_AW-1:0] X_BASE_A = GB_AW'(X_BASE);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CLEAR    = 3'd1;
  localparam logic [2:0] S_LD_RD    = 3'd2;
  localparam logic [2:0] S_LD_WR    = 3'd3;
  localparam logic [2:0] S_CA_RD    = 3'd4;
  localparam logic [2:0] S_CA_ISSUE = 3'd5;
  localparam logic [2:0] S_CA_WAIT  = 3'd6;
  localparam logic [2:0] S_DONE     = 3'd7;

  logic [2:0]       state_q,    state_d;
  logic [IW-1:0]    i_q,        i_d;
  logic [CW-1:0]    cnt_q,      cnt_d;
  logic             err_q,      err_d;
  logic [31:0]      result_q,   result_d;
  logic [31:0]      ain_q,      ain_d;
  logic             busy_q,     busy_d;
  logic             done_q,     done_d;
  logic             gb_en_q,    gb_en_d;
  logic [GB_AW-1:0] gb_addr_q,  gb_addr_d;
  logic             pe_clr_n_q, pe_clr_n_d;
  logic             pe_we_q,    pe_we_d;
  logic             pe_valid_q, pe_valid_d;
  logic [PE_AW-1:0] pe_addr_q,  pe_addr_d;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    result_d = result_q;
    ain_d    = ain_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          err_d   = 1'b0;
          i_d     = '0;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: state_d = S_LD_RD;
      S_LD_RD: state_d = S_LD_WR;
      S_LD_WR: begin
        if (i_q == LAST_IDX) begin
          i_d     = '0;
          state_d = S_CA_RD;
        end else begin
          i_d     = i_q + IW'(1);
          state_d = S_LD_RD;
        end
      end
      S_CA_RD: state_d = S_CA_ISSUE;
      S_CA_ISSUE: begin
        cnt_d   = '0;
        ain_d   = bus.gb_dout;
        state_d = S_CA_WAIT;
      end
      S_CA_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        // A result arriving in the last allowed cycle beats the timeout.
        if (bus.pe_dvalid) begin
          if (i_q == LAST_IDX) begin
            result_d = bus.pe_dout;
            state_d  = S_DONE;
          end else begin
            i_d     = i_q + IW'(1);
            state_d = S_CA_RD;
          end
        end else if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up
  // with the state they belong to.
  always_comb begin
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
    gb_en_d    = (state_d == S_LD_RD) || (state_d == S_CA_RD);
    gb_addr_d  = gb_addr_q;
    pe_clr_n_d = (state_d != S_CLEAR);
    pe_we_d    = (state_d == S_LD_WR);
    pe_valid_d = (state_d == S_CA_ISSUE);
    pe_addr_d  = pe_addr_q;
    case (state_d)
      S_LD_RD:            gb_addr_d = W_BASE_A + GB_AW'(i_d);
      S_CA_RD:            gb_addr_d = X_BASE_A + GB_AW'(i_d);
      S_LD_WR, S_CA_ISSUE: pe_addr_d = PE_AW'(i_d);
      default: ;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      i_q        <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      result_q   <= '0;
      ain_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      gb_en_q    <= 1'b0;
      gb_addr_q  <= '0;
      pe_clr_n_q <= 1'b1;
      pe_we_q    <= 1'b0;
      pe_valid_q <= 1'b0;
      pe_addr_q  <= '0;
    end else begin
      i_q        <= i_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      result_q   <= result_d;
      ain_q      <= ain_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      gb_en_q    <= gb_en_d;
      gb_addr_q  <= gb_addr_d;
      pe_clr_n_q <= pe_clr_n_d;
      pe_we_q    <= pe_we_d;
      pe_valid_q <= pe_valid_d;
      pe_addr_q  <= pe_addr_d;
    end
  end

  // Buffer data only arrives in the write/issue cycle itself, so it is
  // forwarded directly there; the operand is then held from ain_q.
  assign bus.pe_din   = pe_we_q ? bus.gb_dout : '0;
  assign bus.pe_ain   = (state_q == S_CA_ISSUE) ? bus.gb_dout : ain_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.result   = result_q;
  assign bus.gb_en    = gb_en_q;
  assign bus.gb_addr  = gb_addr_q;
  assign bus.pe_clr_n = pe_clr_n_q;
  assign bus.pe_we    = pe_we_q;
  assign bus.pe_valid = pe_valid_q;
  assign bus.pe_addr  = pe_addr_q;
endmodule
`default_nettype wire

// File: tb/tb_pe_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_pe_seq_ctrl
// Brief   : Self-checking bench for pe_seq_ctrl with buffer and MAC PE models.
// Revision: 1.0
// ============================================================================
module tb_pe_seq_ctrl;
  localparam int N       = 16;
  localparam int PE_AW   = 6;
  localparam int GB_AW   = 8;
  localparam int W_BASE  = 0;
  localparam int X_BASE  = 16;
  localparam int TIMEOUT = 255;

  logic aclk = 1'b0;
  logic aresetn;
  always #5 aclk = ~aclk;

  pe_seq_ctrl_if #(.GB_AW(GB_AW), .PE_AW(PE_AW)) bus();

  pe_seq_ctrl #(
    .N(N), .PE_AW(PE_AW), .GB_AW(GB_AW),
    .W_BASE(W_BASE), .X_BASE(X_BASE), .TIMEOUT(TIMEOUT)
  ) dut (
    .aclk   (aclk),
    .aresetn(aresetn),
    .bus    (bus)
  );

  logic [31:0] gb_mem [256];
  logic        inj;
  logic        mdl_dvalid;
  logic [31:0] mdl_dout;
  int          pe_lat;
  int          pe_drop;
  int          n_checks;
  int          n_fails;
  logic [31:0] last_result;

  assign bus.pe_dvalid = mdl_dvalid | inj;
  assign bus.pe_dout   = mdl_dout;

  // Single-port buffer, 1-cycle latency; junk on the bus when not read.
  always @(posedge aclk) bus.gb_dout <= bus.gb_en ? gb_mem[bus.gb_addr] : $urandom;

  // MAC processing element with programmable latency and an optional element
  // that never answers.
  logic        pe_rst_n;
  logic [31:0] wmem [64];
  logic [31:0] acc, pend_val;
  int          pc;
  bit          pend;
  assign pe_rst_n = aresetn & bus.pe_clr_n;

  always @(posedge aclk or negedge pe_rst_n) begin
    if (!pe_rst_n) begin
      acc        <= '0;
      mdl_dvalid <= 1'b0;
      mdl_dout   <= '0;
      pend       <= 1'b0;
      pc         <= 0;
    end else begin
      mdl_dvalid <= 1'b0;
      if (bus.pe_we) wmem[bus.pe_addr] <= bus.pe_din;
      if (bus.pe_valid) begin
        if (int'(bus.pe_addr) == pe_drop) begin
          pend <= 1'b0;
        end else if (pe_lat == 1) begin
          mdl_dvalid <= 1'b1;
          mdl_dout   <= acc + wmem[bus.pe_addr] * bus.pe_ain;
          acc        <= acc + wmem[bus.pe_addr] * bus.pe_ain;
        end else begin
          pend     <= 1'b1;
          pend_val <= acc + wmem[bus.pe_addr] * bus.pe_ain;
          pc       <= pe_lat - 1;
        end
      end else if (pend) begin
        if (pc == 1) begin
          mdl_dvalid <= 1'b1;
          mdl_dout   <= pend_val;
          acc        <= pend_val;
          pend       <= 1'b0;
        end
        pc <= pc - 1;
      end
    end
  end

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string nm);
    check_val({nm, "_busy"},     longint'(bus.busy),     0);
    check_val({nm, "_done"},     longint'(bus.done),     0);
    check_val({nm, "_err"},      longint'(bus.err),      0);
    check_val({nm, "_result"},   longint'(bus.result),   0);
    check_val({nm, "_gb_en"},    longint'(bus.gb_en),    0);
    check_val({nm, "_gb_addr"},  longint'(bus.gb_addr),  0);
    check_val({nm, "_pe_clr_n"}, longint'(bus.pe_clr_n), 1);
    check_val({nm, "_pe_we"},    longint'(bus.pe_we),    0);
    check_val({nm, "_pe_valid"}, longint'(bus.pe_valid), 0);
    check_val({nm, "_pe_addr"},  longint'(bus.pe_addr),  0);
    check_val({nm, "_pe_din"},   longint'(bus.pe_din),   0);
    check_val({nm, "_pe_ain"},   longint'(bus.pe_ain),   0);
  endtask

  task automatic fill_rand();
    for (int k = 0; k < N; k++) begin
      gb_mem[W_BASE + k] = $urandom;
      gb_mem[X_BASE + k] = $urandom;
    end
  endtask

  // One job from start to done; expectations come from the dot product and
  // the documented cycle formula.
  task automatic run_job(input int lat, input int drop, input int restart_at,
                         input bit inject, input int reset_elem, input string nm);
    logic [31:0] exp_res, held_ain;
    int  exp_done, exp_valid, cyc, done_cyc, done_cnt, busy_cnt, clr_cnt, clr_cyc;
    int  we_cnt, we_bad, valid_cnt, prev_vaddr, hold_bad, held_addr;
    bit  exp_err, busy_after, err_c1, done_seen, in_wait;
    pe_lat = lat;
    pe_drop = drop;
    exp_res = '0;
    for (int k = 0; k < N; k++) exp_res += gb_mem[W_BASE + k] * gb_mem[X_BASE + k];
    if (drop >= 0) begin
      exp_res   = last_result;
      exp_err   = 1'b1;
      exp_done  = 2 * N + 4 + drop * (2 + lat) + TIMEOUT;
      exp_valid = drop + 1;
    end else begin
      exp_err   = 1'b0;
      exp_done  = 2 + 2 * N + N * (2 + lat);
      exp_valid = N;
    end
    done_cyc = -1; done_cnt = 0; busy_cnt = 0; clr_cnt = 0; clr_cyc = -1;
    we_cnt = 0; we_bad = 0; valid_cnt = 0; prev_vaddr = -1; hold_bad = 0;
    held_addr = 0; held_ain = '0;
    busy_after = 1'b1; err_c1 = 1'b1; done_seen = 1'b0; in_wait = 1'b0;

    @(negedge aclk); bus.start = 1'b1;
    @(negedge aclk); cyc = 1;
    while (cyc < 2000 && !(done_seen && cyc > done_cyc + 1)) begin
      bus.start = (restart_at > 0 && cyc == restart_at);
      inj = inject && (bus.pe_we || bus.pe_valid);
      if (reset_elem >= 0 && prev_vaddr == reset_elem) begin
        aresetn = 1'b0; inj = 1'b0; bus.start = 1'b0;
        #1;
        check_reset({nm, "_rst"});
        repeat (3) begin
          @(negedge aclk);
          if (bus.done) done_cnt++;
        end
        check_val({nm, "_rst_nodone"}, done_cnt, 0);
        aresetn = 1'b1;
        last_result = '0;
        @(negedge aclk);
        return;
      end
      if (bus.busy) busy_cnt++;
      if (done_seen && cyc == done_cyc + 1) busy_after = bus.busy;
      if (cyc == 1) err_c1 = bus.err;
      if (!bus.pe_clr_n) begin clr_cnt++; clr_cyc = cyc; end
      if (bus.pe_we) begin
        if (we_cnt >= N || cyc != 3 + 2 * we_cnt || int'(bus.pe_addr) != we_cnt ||
            bus.pe_din !== gb_mem[W_BASE + (we_cnt % N)]) we_bad++;
        we_cnt++;
      end
      if (bus.pe_we && bus.pe_valid) we_bad++;
      if (in_wait && !(bus.gb_en || bus.done) &&
          (bus.pe_ain !== held_ain || int'(bus.pe_addr) != held_addr)) hold_bad++;
      if (bus.pe_valid) begin
        valid_cnt++;
        in_wait = 1'b1; held_ain = bus.pe_ain; held_addr = int'(bus.pe_addr);
      end else if (bus.gb_en || bus.done) begin
        in_wait = 1'b0;
      end
      prev_vaddr = bus.pe_valid ? int'(bus.pe_addr) : -1;
      if (bus.done) begin
        done_cnt++;
        if (!done_seen) begin done_seen = 1'b1; done_cyc = cyc; end
      end
      @(negedge aclk); cyc++;
    end
    bus.start = 1'b0; inj = 1'b0;
    check_val({nm, "_done_cyc"},   done_cyc,             exp_done);
    check_val({nm, "_done_cnt"},   done_cnt,             1);
    check_val({nm, "_result"},     longint'(bus.result), longint'(exp_res));
    check_val({nm, "_err"},        longint'(bus.err),    longint'(exp_err));
    check_val({nm, "_busy_cnt"},   busy_cnt,             exp_done);
    check_val({nm, "_busy_after"}, longint'(busy_after), 0);
    check_val({nm, "_err_c1"},     longint'(err_c1),     0);
    check_val({nm, "_clr_cnt"},    clr_cnt,              1);
    check_val({nm, "_clr_cyc"},    clr_cyc,              1);
    check_val({nm, "_we_cnt"},     we_cnt,               N);
    check_val({nm, "_we_bad"},     we_bad,               0);
    check_val({nm, "_valid_cnt"},  valid_cnt,            exp_valid);
    check_val({nm, "_hold_bad"},   hold_bad,             0);
    if (drop < 0) last_result = exp_res;
  endtask

  initial begin
    n_checks = 0; n_fails = 0; last_result = '0;
    aresetn = 1'b0; bus.start = 1'b0; inj = 1'b0; pe_lat = 1; pe_drop = -1;
    for (int a = 0; a < 256; a++) gb_mem[a] = $urandom;
    repeat (3) @(negedge aclk);
    check_reset("por");
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);

    for (int k = 0; k < N; k++) begin
      gb_mem[W_BASE + k] = 32'h3f80_0000;
      gb_mem[X_BASE + k] = 32'h4000_0000;
    end
    run_job(4, -1, 0, 1'b0, -1, "ones");

    for (int k = 0; k < N; k++) begin
      gb_mem[W_BASE + k] = 32'h3f80_0000 + (32'(k) << 22);
      gb_mem[X_BASE + k] = 32'h3f80_0000;
    end
    run_job(1, -1, 0, 1'b0, -1, "ramp");

    for (int j = 0; j < 4; j++) begin
      fill_rand();
      run_job(int'($urandom_range(1, 5)), -1, 0, 1'b0, -1, $sformatf("rnd%0d", j));
    end

    fill_rand();
    run_job(4, 5, 0, 1'b0, -1, "tmo");
    fill_rand();
    run_job(3, -1, 0, 1'b0, -1, "after_tmo");

    fill_rand();
    run_job(2, -1, 40, 1'b0, -1, "restart");

    fill_rand();
    run_job(3, -1, 0, 1'b1, -1, "inject");

    fill_rand();
    run_job(3, -1, 0, 1'b0, 7, "midrst");
    run_job(2, -1, 0, 1'b0, -1, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
`default_nettype wire
